// File: rtl/muldiv_pkg.sv
// RV32M multiply/divide shared definitions: func3 codes, FSM encoding, op-class helpers.
// Width-independent; datapath widths live with the modules.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic op1_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic op2_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic is_rem(input logic [2:0] f3);
        return f3[2] & f3[1];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
// master = pipeline side, slave = muldiv_unit.
interface muldiv_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       func3;
    logic [XLEN-1:0]  operand1;
    logic [XLEN-1:0]  operand2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, func3, operand1, operand2, in_tag, out_ready,
        input  in_ready, out_valid, result, out_tag
    );

    modport slave (
        input  in_valid, func3, operand1, operand2, in_tag, out_ready,
        output in_ready, out_valid, result, out_tag
    );
endinterface

// File: rtl/muldiv_div_core.sv
// Restoring unsigned divider datapath: one quotient bit per step, magnitudes only.
// Latency: XLEN steps after load; no handshake, the caller sequences load/step.
// Backpressure: none; state simply holds while step is low.
module muldiv_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quo_nxt,
    output logic [XLEN-1:0] rem_nxt
);

    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dsr_q;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            ge;

    // Partial remainder stays below the divisor, so a negative trial shows in the top bit.
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign diff    = shifted - {1'b0, dsr_q};
    assign ge      = ~diff[XLEN];
    assign rem_nxt = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_nxt = {quo_q[XLEN-2:0], ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
            dsr_q <= divisor;
        end else if (step) begin
            quo_q <= quo_nxt;
            rem_q <= rem_nxt;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multi-cycle mul/div execute unit; MULDIV_FAST_MUL_EN selects a one-shot multiplier.
// Latency (request cycle to out_valid): XLEN+1 iterative, 1 for divide special cases / fast MUL.
// Backpressure: one op in flight, in_ready low until the result is taken with out_ready.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    flush,
    muldiv_if.slave bus,
    output logic    busy
);

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  XMIN     = {1'b1, {(XLEN-1){1'b0}}};

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       f3_q;
    logic             neg_q, neg_r;
    logic [TAG_W-1:0] tag_q;
    logic [XLEN-1:0]  result_q;

    logic             accept, iterating, last_step;
    logic             s1, s2, div_zero, div_ovf, special;
    logic [XLEN-1:0]  mag1, mag2, special_res, mul_res;
    logic [XLEN-1:0]  quo_nxt, rem_nxt, div_res;

    function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] p, input logic neg,
                                                 input logic [2:0] f3);
        logic [2*XLEN-1:0] s;
        s = neg ? -p : p;
        return (f3 == F3_MUL) ? s[XLEN-1:0] : s[2*XLEN-1:XLEN];
    endfunction

    assign accept    = (state == ST_IDLE) && bus.in_valid && !flush;
    assign iterating = (state == ST_MUL) || (state == ST_DIV);
    assign last_step = iterating && (cnt == CNT_LAST);

    assign s1   = op1_signed(bus.func3) && bus.operand1[XLEN-1];
    assign s2   = op2_signed(bus.func3) && bus.operand2[XLEN-1];
    assign mag1 = s1 ? -bus.operand1 : bus.operand1;
    assign mag2 = s2 ? -bus.operand2 : bus.operand2;

    assign div_zero    = (bus.operand2 == '0);
    assign div_ovf     = op1_signed(bus.func3) && (bus.operand1 == XMIN) && (bus.operand2 == '1);
    assign special     = is_div(bus.func3) && (div_zero || div_ovf);
    assign special_res = div_zero ? (is_rem(bus.func3) ? bus.operand1 : '1)
                                  : (is_rem(bus.func3) ? '0 : bus.operand1);

`ifdef MULDIV_FAST_MUL_EN
    localparam state_t MUL_NEXT = ST_DONE;
    logic [2*XLEN-1:0] fast_prod;

    assign fast_prod = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
    assign mul_res   = mul_pick(fast_prod, s1 ^ s2, bus.func3);
`else
    localparam state_t MUL_NEXT = ST_MUL;
    logic [2*XLEN-1:0] prod, prod_nxt;
    logic [XLEN-1:0]   mcand;
    logic [XLEN:0]     prod_sum;

    // Low half starts as the multiplier and is shifted out as the product grows in.
    assign prod_sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
    assign prod_nxt = {prod_sum, prod[XLEN-1:1]};
    assign mul_res  = mul_pick(prod_nxt, neg_q, f3_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod  <= '0;
            mcand <= '0;
        end else if (accept && !is_div(bus.func3)) begin
            prod  <= {{XLEN{1'b0}}, mag2};
            mcand <= mag1;
        end else if ((state == ST_MUL) && !flush) begin
            prod <= prod_nxt;
        end
    end
`endif

    muldiv_div_core #(.XLEN(XLEN)) u_div_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept && is_div(bus.func3) && !special),
        .step     ((state == ST_DIV) && !flush),
        .dividend (mag1),
        .divisor  (mag2),
        .quo_nxt  (quo_nxt),
        .rem_nxt  (rem_nxt)
    );

    assign div_res = is_rem(f3_q) ? (neg_r ? -rem_nxt : rem_nxt)
                                  : (neg_q ? -quo_nxt : quo_nxt);

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (accept && is_div(bus.func3)) state_d = special ? ST_DONE : ST_DIV;
                else if (accept)                 state_d = MUL_NEXT;
            end
            ST_MUL, ST_DIV: if (last_step) state_d = ST_DONE;
            ST_DONE:        if (bus.out_ready) state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            tag_q    <= '0;
            result_q <= '0;
        end else begin
            state <= state_d;
            if (flush) begin
                cnt <= '0;
            end else if (accept) begin
                f3_q  <= bus.func3;
                tag_q <= bus.in_tag;
                neg_q <= s1 ^ s2;
                neg_r <= s1;
                cnt   <= '0;
                if (special) result_q <= special_res;
`ifdef MULDIV_FAST_MUL_EN
                else if (!is_div(bus.func3)) result_q <= mul_res;
`endif
            end else if (iterating) begin
                cnt <= last_step ? '0 : cnt + 1'b1;
                // Sign fix rides on the final step so DONE holds the finished value.
                if (last_step) result_q <= (state == ST_DIV) ? div_res : mul_res;
            end
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.result    = result_q;
    assign bus.out_tag   = tag_q;
    assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: products, divides, corner cases,
// output hold under backpressure, flush and asynchronous reset mid-operation.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam int DIV_LAT = XLEN + 1;
    localparam int SPC_LAT = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic busy;
    int   n_cmp = 0;
    int   n_bad = 0;

    muldiv_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one request and returns just after the accepting edge.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        int w = 0;
        while (!bus.in_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        check("in_ready_before_issue", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.func3    = f3;
        bus.operand1 = a;
        bus.operand2 = b;
        bus.in_tag   = tag;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Cycles from the request cycle until out_valid is seen (1 = visible right after accept).
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp,
                          input int exp_lat);
        int lat;
        issue(f3, a, b, tag);
        wait_valid(lat);
        check({name, "_lat"}, 64'(lat), 64'(exp_lat));
        check({name, "_res"}, 64'(bus.result), 64'(exp));
        check({name, "_tag"}, 64'(bus.out_tag), 64'(tag));
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        int seen;
        bus.in_valid  = 1'b0;
        bus.func3     = 3'b000;
        bus.operand1  = '0;
        bus.operand2  = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("mulhu_ff", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mul_ff", F3_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0001, MUL_LAT);
        run_op("mul_lo", F3_MUL, 32'h1234_5678, 32'h0000_0010, 5'd3, 32'h2345_6780, MUL_LAT);
        run_op("mulh_min", F3_MULH, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, MUL_LAT);
        run_op("mulhsu_m1", F3_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd5, 32'hFFFF_FFFF, MUL_LAT);

        run_op("div_m7_2", F3_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6, 32'hFFFF_FFFD, DIV_LAT);
        run_op("rem_m7_2", F3_REM, 32'hFFFF_FFF9, 32'h0000_0002, 5'd7, 32'hFFFF_FFFF, DIV_LAT);
        run_op("divu_100_7", F3_DIVU, 32'd100, 32'd7, 5'd8, 32'd14, DIV_LAT);
        run_op("remu_100_7", F3_REMU, 32'd100, 32'd7, 5'd9, 32'd2, DIV_LAT);

        run_op("div_by0", F3_DIV, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, SPC_LAT);
        run_op("remu_by0", F3_REMU, 32'd5, 32'd0, 5'd11, 32'd5, SPC_LAT);
        run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, SPC_LAT);
        run_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, SPC_LAT);
        run_op("divu_min_m1", F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, DIV_LAT);

        // Result held in DONE while the consumer stalls.
        bus.out_ready = 1'b0;
        issue(F3_DIVU, 32'd100, 32'd7, 5'd21);
        wait_valid(lat);
        check("hold_lat", 64'(lat), 64'(DIV_LAT));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold_result", 64'(bus.result), 64'd14);
            check("hold_tag", 64'(bus.out_tag), 64'd21);
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
            check("hold_out_valid", 64'(bus.out_valid), 64'd1);
        end
        check("hold_busy", 64'(busy), 64'd1);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready", 64'(bus.in_ready), 64'd1);
        check("release_out_valid", 64'(bus.out_valid), 64'd0);

        // Flush wins over a request in IDLE.
        bus.in_valid = 1'b1;
        bus.func3    = F3_DIVU;
        bus.operand1 = 32'd9;
        bus.operand2 = 32'd0;
        bus.in_tag   = 5'd30;
        flush        = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        check("idle_flush_busy", 64'(busy), 64'd0);
        check("idle_flush_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        check("idle_flush_out_valid", 64'(bus.out_valid), 64'd0);

        // Flush part-way through a divide: no result, unit free next cycle.
        issue(F3_DIV, 32'd100, 32'd7, 5'd3);
        repeat (9) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_in_ready", 64'(bus.in_ready), 64'd1);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1;
        end
        check("flush_no_result", 64'(seen), 64'd0);
        run_op("divu_9_3", F3_DIVU, 32'd9, 32'd3, 5'd7, 32'd3, DIV_LAT);

        // Asynchronous reset mid-multiply.
        issue(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", 64'(bus.in_ready), 64'd1);
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_result", 64'(bus.result), 64'd0);
        check("arst_out_tag", 64'(bus.out_tag), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("post_rst_remu", F3_REMU, 32'd100, 32'd7, 5'd19, 32'd2, DIV_LAT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
